univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/shift_pkg.sv | 36 +++
 rtl/shift_step.sv | 48 ++++
 rtl/univ_shift_reg.sv | 116 +++++++++++
 tb/tb_univ_shift_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states, amount width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package shift_pkg;

    // Operation codes carried on the mode input
    typedef enum logic [2:0] {
        MODE_NOP  = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_CLR  = 3'b010,
        MODE_SHL  = 3'b011,
        MODE_SHR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ROR  = 3'b110,
        MODE_ASR  = 3'b111
    } mode_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Shift-amount width: one extra bit so amounts up to 2*WIDTH-1 are expressible
    function automatic int amt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    // True for modes that iterate one bit per cycle in RUN
    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift/rotate step for the universal shift register.
// Latency: purely combinational.
// Backpressure: none; output always reflects current inputs.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_e             mode,
    input  logic [WIDTH-1:0]  q,
    input  logic              sin,
    output logic [WIDTH-1:0]  next_q,
    output logic              out_bit
);

    // One-bit move; non-shift modes pass the value through untouched
    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_q  = {q[WIDTH-2:0], sin};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q  = {sin, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/clear/shift/rotate, multi-bit shifts done one bit per cycle.
// Latency: done in cycle N+1 after accept (1 cycle for NOP/LOAD/CLR/amt=0).
// Backpressure: start is ignored while busy; requester must wait for busy low.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = amt_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [AMT_W-1:0]  amt,
    input  logic [WIDTH-1:0]  din,
    input  logic              sin,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qbar,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [AMT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              sout_q, sout_d;

    logic [WIDTH-1:0]  step_q;
    logic              step_out;
    mode_e             req_mode;

    assign req_mode = mode_e'(mode);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode    (mode_q),
        .q       (q_q),
        .sin     (sin),
        .next_q  (step_q),
        .out_bit (step_out)
    );

    // State register plus datapath registers; reset overrides any request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NOP;
            count_q <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
        end
    end

    // Next-state: immediate ops and zero-length shifts finish straight away
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift(req_mode) && (amt != '0)) state_d = ST_RUN;
                    else                                   state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                if (count_q == AMT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latch the request on accept, one step per RUN cycle
    always_comb begin
        mode_d  = mode_q;
        count_d = count_q;
        q_d     = q_q;
        sout_d  = sout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = req_mode;
                    case (req_mode)
                        MODE_LOAD: q_d = din;
                        MODE_CLR:  q_d = '0;
                        MODE_NOP:  q_d = q_q;
                        default:   count_d = amt;
                    endcase
                end
            end
            ST_RUN: begin
                q_d     = step_q;
                sout_d  = step_out;
                count_d = count_q - AMT_W'(1);
            end
            default: ;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign sout = sout_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mode;
    logic [3:0]  amt;
    logic [7:0]  din;
    logic        sin;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic        sout;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .din   (din),
        .sin   (sin),
        .q     (q),
        .qbar  (qbar),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then watch busy/done until idle.
    // With hold set, start stays high requesting LOAD 0xFF during the operation.
    task automatic do_op(input string tag, input logic [2:0] m, input logic [3:0] a,
                         input logic [7:0] d, input logic s, input int exp_lat,
                         input bit hold);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        int i        = 1;
        start = 1'b1; mode = m; amt = a; din = d; sin = s;
        tick();
        if (hold) begin
            mode = MODE_LOAD; din = 8'hFF; amt = 4'd1;
        end else begin
            start = 1'b0; mode = MODE_LOAD; din = 8'h66; amt = 4'd7;
        end
        while (busy && i <= 40) begin
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            tick();
            i++;
        end
        start = 1'b0;
        chk($sformatf("%s busy_cycles", tag), 64'(busy_cnt), 64'(exp_lat));
        chk($sformatf("%s done_pulses", tag), 64'(done_cnt), 64'd1);
        chk($sformatf("%s done_cycle", tag),  64'(done_at),  64'(exp_lat));
    endtask

    task automatic load(input logic [7:0] v);
        do_op("load", MODE_LOAD, 4'd0, v, 1'b0, 1, 1'b0);
    endtask

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; mode = '0; amt = '0; din = '0; sin = 1'b0;
        tick();
        start = 1'b1; mode = MODE_LOAD; din = 8'h77;
        tick();
        chk("rst q",    64'(q),    64'h00);
        chk("rst qbar", 64'(qbar), 64'hFF);
        chk("rst sout", 64'(sout), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);

        // First edge with rst low and start high accepts LOAD
        rst = 1'b0; mode = MODE_LOAD; din = 8'hA5;
        tick();
        start = 1'b0;
        chk("load q",    64'(q),    64'hA5);
        chk("load qbar", 64'(qbar), 64'h5A);
        chk("load busy", 64'(busy), 64'd1);
        chk("load done", 64'(done), 64'd1);
        tick();
        chk("load busy after", 64'(busy), 64'd0);
        chk("load done after", 64'(done), 64'd0);
        chk("load hold q",     64'(q),    64'hA5);

        load(8'h81);
        do_op("shl3", MODE_SHL, 4'd3, 8'h00, 1'b1, 4, 1'b0);
        chk("shl3 q",    64'(q),    64'h0F);
        chk("shl3 sout", 64'(sout), 64'd0);

        load(8'h90);
        do_op("asr2", MODE_ASR, 4'd2, 8'h00, 1'b0, 3, 1'b0);
        chk("asr2 q",    64'(q),    64'hE4);
        chk("asr2 sout", 64'(sout), 64'd0);

        load(8'h01);
        do_op("ror9", MODE_ROR, 4'd9, 8'h00, 1'b0, 10, 1'b0);
        chk("ror9 q",    64'(q),    64'h80);
        chk("ror9 sout", 64'(sout), 64'd1);

        // LOAD leaves sout alone; a zero-length shift leaves both q and sout alone
        load(8'h3C);
        chk("load keeps sout", 64'(sout), 64'd1);
        do_op("shr0", MODE_SHR, 4'd0, 8'h00, 1'b0, 1, 1'b0);
        chk("shr0 q",    64'(q),    64'h3C);
        chk("shr0 sout", 64'(sout), 64'd1);

        // start held high with LOAD 0xFF during a shift must be ignored
        load(8'hB4);
        do_op("shr4hold", MODE_SHR, 4'd4, 8'h00, 1'b0, 5, 1'b1);
        chk("shr4hold q",    64'(q),    64'h0B);
        chk("shr4hold sout", 64'(sout), 64'd0);
        tick();
        chk("shr4hold idle busy", 64'(busy), 64'd0);
        chk("shr4hold idle q",    64'(q),    64'h0B);

        load(8'h96);
        do_op("rol3", MODE_ROL, 4'd3, 8'h00, 1'b0, 4, 1'b0);
        chk("rol3 q",    64'(q),    64'hB4);
        chk("rol3 sout", 64'(sout), 64'd0);

        // Over-length shift saturates to the fill bit
        load(8'h5A);
        do_op("shr12", MODE_SHR, 4'd12, 8'h00, 1'b1, 13, 1'b0);
        chk("shr12 q",    64'(q),    64'hFF);
        chk("shr12 sout", 64'(sout), 64'd1);

        do_op("clr", MODE_CLR, 4'd5, 8'h12, 1'b0, 1, 1'b0);
        chk("clr q", 64'(q), 64'h00);

        do_op("nop", MODE_NOP, 4'd3, 8'h12, 1'b0, 1, 1'b0);
        chk("nop q", 64'(q), 64'h00);

        // Reset during the second RUN cycle aborts with no done pulse
        load(8'h81);
        start = 1'b1; mode = MODE_SHL; amt = 4'd5; sin = 1'b1;
        tick();
        start = 1'b0;
        chk("abort run busy", 64'(busy), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort q",    64'(q),    64'h00);
        chk("abort sout", 64'(sout), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) dn++;
            tick();
        end
        chk("abort quiet", 64'(dn), 64'd0);
        load(8'hC3);
        chk("post-abort load q", 64'(q), 64'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck design still produces a summary
    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
